tt_um_ihp_uart_tx: RTL and testbench
====================================

# tt_um_ihp_uart_tx

Byte-wide UART transmitter packaged as a Tiny Tapeout user project for the IHP shuttle. It accepts a parallel byte on the dedicated inputs and a start strobe on the bidirectional pins. It serializes the byte onto a single output pin as an 8-N-1 frame, or as 8-E-1 when parity is enabled. It is the outbound side of the parallel-in, parallel-out datapath: the host presents data in parallel, and this block drives it off-chip serially with a busy/done handshake.

## Interface
Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 4..65535; bit counter width $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- ena  input  1  always 1 when powered; ignored.
- ui_in  input  8  data byte to transmit; sampled in the capture cycle.
- uio_in  input  8  [0] start strobe (asynchronous to clk); [1] parity enable (sampled in capture cycle); [7:2] unused.
- uo_out  output  8  [0] tx serial line (idle 1); [1] busy; [2] done (1-cycle pulse); [7:3] = 0.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0 (all uio pins are inputs).

## Operation
- Start synchronizer: s1 <- uio_in[0], s2 <- s1, s3 <- s2; all three reset to 1. start_edge = s2 & ~s3.
  - A strobe held high through reset release does not trigger; a low-to-high transition is required.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, busy=0.
  - On start_edge, capture ui_in into shift register and uio_in[1] into par_en.
  - Clear bit counter and even-parity accumulator; go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: tx = shift[0], LSB first, CLKS_PER_BIT cycles per bit.
  - At each bit end, shift right, XOR the sent bit into parity, increment index.
  - After bit 7: go to PARITY if par_en, else STOP.
- PARITY: tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then assert done for one cycle, deassert busy, return to IDLE.
- busy=1 in all states except IDLE.
- start_edge while busy is discarded. It is not queued.
- ui_in and uio_in[1] must be held stable from the start strobe through the capture cycle. After capture, changes have no effect on the frame in flight.
- tx, busy, and done are registered outputs; there are no combinational paths from inputs.

## Timing
- Reset (rst_n low at a clock edge): after that edge, uo_out=8'h01 (tx=1, busy=0, done=0), FSM=IDLE, s1..s3=1, counters=0. uio_out=0, uio_oe=0 at all times.
- Reset mid-frame: the frame aborts at the next edge. tx=1, busy=0, no done pulse.
- Start latency:
  - uio_in[0] is first sampled high at edge E0 (after being low at E-1).
  - Capture occurs at edge E2.
  - From E2, tx=0 and busy=1.
- Frame length: N = 10 bits (11 with parity) × CLKS_PER_BIT cycles of busy=1. Each bit level is held exactly CLKS_PER_BIT cycles.
- done=1 for exactly one cycle: the cycle immediately after the last STOP cycle. busy=0 and tx=1 in that same cycle.
- Back-to-back: a start_edge in the done cycle or later is accepted. A start_edge during the last STOP cycle is dropped.
- Strobe held high across multiple frames yields exactly one frame.

## Test plan
- Reset: hold rst_n=0 for 5 cycles with random ui_in/uio_in -> uo_out=8'h01, uio_out=0, uio_oe=0. Then uio_in[0] held high through rst_n release -> no frame.
- Plain frame, CLKS_PER_BIT=4: ui_in=8'hA5, uio_in[1]=0, pulse uio_in[0] -> tx from E2 is 0,1,0,1,0,0,1,0,1,1.
  - Each level lasts 4 cycles.
  - busy=1 for 40 cycles; done pulses once; uo_out[7:3]=0 throughout.
- Parity frame: ui_in=8'h07, uio_in[1]=1 -> tx 0,1,1,1,0,0,0,0,0,1(parity),1.
  - busy=1 for 44 cycles.
  - Repeat with 8'h03 -> parity bit 0.
- Busy rejection: second start pulse with ui_in=8'hFF during bit 3 of an 8'h00 frame -> only the 8'h00 frame is sent. Strobe held high for 200 cycles -> exactly one frame.
- Reset mid-frame: drive rst_n=0 for 1 cycle during data bit 4 -> next cycle tx=1 and busy=0; no done. A fresh strobe then sends a complete correct frame.
- Back-to-back: strobe rising edge timed so that capture lands in the done cycle, with ui_in=8'h5A -> tx goes low immediately. The second frame is correct with no extra idle bit.

Source files
------------

// File: rtl/tt_um_ihp_uart_tx.sv
// Byte-wide UART transmitter (8-N-1, or 8-E-1 with parity enabled) for Tiny Tapeout.
// The start strobe is synchronized and edge-detected; tx, busy and done are all registered.
module tt_um_ihp_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             par_en_q, par_en_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_edge;
    logic             bit_end;
    logic             unused_in;

    assign unused_in  = &{1'b0, ena, uio_in[7:2]};

    // Synchronizer resets to all ones so a strobe held through reset release never fires.
    assign start_edge = sync_q[1] & ~sync_q[2];
    assign bit_end    = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        par_en_d = par_en_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start_edge) begin
                    shift_d  = ui_in;
                    par_en_d = uio_in[1];
                    cnt_d    = '0;
                    idx_d    = '0;
                    par_d    = 1'b0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    par_d   = par_q ^ shift_q[0];
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        if (par_en_q) begin
                            tx_d    = par_q ^ shift_q[0];
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        tx_d = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sync_q   <= 3'b111;
            cnt_q    <= '0;
            idx_q    <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[1:0], uio_in[0]};
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Data shift register carries no reset; it is always loaded on capture.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign uo_out  = {5'b0, done_q, busy_q, tx_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_ihp_uart_tx.sv
// Directed bench for tt_um_ihp_uart_tx with CLKS_PER_BIT=4; expected frames are hand-written
// as {stop, [parity], data, start} bit vectors transmitted LSB first.
module tb_tt_um_ihp_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests = 0;
    int fails = 0;

    tt_um_ihp_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d]: observed %02h expected %02h", tag, idx, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, i, uo_out, 8'h01);
        end
    endtask

    // Raises the strobe; returns just after the capture edge E2.
    task automatic start_frame(input logic [7:0] d, input logic p, input logic hold, input string tag);
        ui_in     = d;
        uio_in[1] = p;
        uio_in[0] = 1'b1;
        tick();
        chk(tag, 0, uo_out, 8'h01);
        tick();
        chk(tag, 1, uo_out, 8'h01);
        tick();
        if (!hold) uio_in[0] = 1'b0;
    endtask

    // Checks every busy cycle of a frame, then the done cycle; optionally raises a new
    // strobe (arm_*) just after checking cycle arm_k.
    task automatic check_frame(input logic [10:0] bits, input int nbits, input int arm_k,
                               input logic [7:0] arm_d, input logic arm_p, input string tag);
        for (int k = 0; k < nbits * CPB; k++) begin
            chk(tag, k, uo_out, {5'b0, 1'b0, 1'b1, bits[k / CPB]});
            if (k == arm_k) begin
                ui_in     = arm_d;
                uio_in[1] = arm_p;
                uio_in[0] = 1'b1;
            end
            tick();
        end
        chk({tag, "_done"}, 0, uo_out, 8'h05);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
            tick();
            chk("rst_uo", i, uo_out, 8'h01);
            chk("rst_uio_out", i, uio_out, 8'h00);
            chk("rst_uio_oe", i, uio_oe, 8'h00);
        end
        uio_in = 8'h01;
        ui_in  = 8'hFF;
        tick();
        rst_n = 1'b1;
        idle_cycles(8, "hold_release");
        uio_in = 8'h00;
        idle_cycles(3, "settle");

        // Plain frame 0xA5: 0,1,0,1,0,0,1,0,1,1
        start_frame(8'hA5, 1'b0, 1'b0, "a5_lat");
        check_frame({1'b0, 1'b1, 8'hA5, 1'b0}, 10, -1, 8'h00, 1'b0, "a5");
        idle_cycles(3, "a5_after");

        // Parity frames: 0x07 -> parity 1, 0x03 -> parity 0
        start_frame(8'h07, 1'b1, 1'b0, "p07_lat");
        check_frame({1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, 8'h00, 1'b0, "p07");
        idle_cycles(3, "p07_after");
        start_frame(8'h03, 1'b1, 1'b0, "p03_lat");
        check_frame({1'b1, 1'b0, 8'h03, 1'b0}, 11, -1, 8'h00, 1'b0, "p03");
        idle_cycles(3, "p03_after");

        // Second strobe with 0xFF during data bit 3 of a 0x00 frame is dropped
        start_frame(8'h00, 1'b0, 1'b0, "rej_lat");
        check_frame({1'b0, 1'b1, 8'h00, 1'b0}, 10, 16, 8'hFF, 1'b0, "rej");
        idle_cycles(12, "rej_idle");
        uio_in[0] = 1'b0;
        idle_cycles(3, "rej_settle");

        // Strobe held high for ~200 cycles yields one frame
        start_frame(8'h3C, 1'b0, 1'b1, "hold_lat");
        check_frame({1'b0, 1'b1, 8'h3C, 1'b0}, 10, -1, 8'h00, 1'b0, "hold");
        idle_cycles(160, "hold_idle");
        uio_in[0] = 1'b0;
        idle_cycles(3, "hold_settle");

        // Reset during data bit 4 of 0xC3 (bit value 0)
        start_frame(8'hC3, 1'b0, 1'b0, "mid_lat");
        repeat (21) tick();
        chk("mid_pre", 0, uo_out, 8'h02);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst", 0, uo_out, 8'h01);
        idle_cycles(50, "mid_nodone");
        start_frame(8'h80, 1'b1, 1'b0, "fresh_lat");
        check_frame({1'b1, 1'b1, 8'h80, 1'b0}, 11, -1, 8'h00, 1'b0, "fresh");
        idle_cycles(3, "fresh_after");

        // Edge landing in the last STOP cycle is dropped
        start_frame(8'h55, 1'b0, 1'b0, "late_lat");
        check_frame({1'b0, 1'b1, 8'h55, 1'b0}, 10, 37, 8'hAA, 1'b0, "late");
        idle_cycles(10, "late_idle");
        uio_in[0] = 1'b0;
        idle_cycles(3, "late_settle");

        // Back-to-back: capture lands in the done cycle
        start_frame(8'h0F, 1'b0, 1'b0, "b2b_lat");
        check_frame({1'b0, 1'b1, 8'h0F, 1'b0}, 10, 38, 8'h5A, 1'b0, "b2b1");
        tick();
        uio_in[0] = 1'b0;
        check_frame({1'b0, 1'b1, 8'h5A, 1'b0}, 10, -1, 8'h00, 1'b0, "b2b2");
        idle_cycles(3, "b2b_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
